// File: rtl/branch_pkg.sv
// Shared definitions for the branch unit: branch opcode encoding, predictor
// counter reset value and the helpers used by the resolve stage.
package branch_pkg;

  // Branch opcode as carried by the execute-stage BrOp field. Codes not
  // listed here decode as "never taken".
  typedef enum logic [4:0] {
    BR_NONE = 5'b00000,
    BR_JUMP = 5'b11111,
    BR_EQ   = 5'b01000,
    BR_NE   = 5'b01001,
    BR_LT   = 5'b01100,
    BR_GE   = 5'b01101,
    BR_LTU  = 5'b01110,
    BR_GEU  = 5'b01111
  } brop_t;

  // Weakly not-taken.
  localparam logic [1:0] CTR_RESET = 2'b01;

  // True for the six compare-and-branch opcodes. These are the only ones
  // that train the predictor and count as branches.
  function automatic logic is_cond_branch(brop_t op);
    case (op)
      BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  // 2-bit saturating counter step: towards 11 when taken, towards 00 when not.
  function automatic logic [1:0] sat_update(logic [1:0] ctr, logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else       return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator.
// Ports:
//   A, B   - operands rs1 / rs2 (XLEN bits)
//   BrOp   - branch opcode (see branch_pkg::brop_t)
//   taken  - 1 when the branch condition holds
module branch_cmp
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [4:0]      BrOp,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (BrOp)
      BR_JUMP: taken = 1'b1;
      BR_EQ:   taken = (A == B);
      BR_NE:   taken = (A != B);
      BR_LT:   taken = ($signed(A) <  $signed(B));
      BR_GE:   taken = ($signed(A) >= $signed(B));
      BR_LTU:  taken = (A <  B);
      BR_GEU:  taken = (A >= B);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit_pred.sv
// Branch unit with bimodal prediction.
// Resolves branch conditions with a one-cycle registered result, keeps a
// direct-mapped table of 2-bit counters that fetch reads combinationally,
// flags mispredictions and keeps saturating branch / mispredict counters.
// Ports:
//   clk, rst        - clock (rising edge), async active-high reset
//   pc_f            - fetch PC; pred_taken_f is the table's prediction for it
//   res_valid_i     - resolve request valid; flush_i kills it this cycle
//   pc_e, A, B, BrOp, pred_taken_e - instruction being resolved
//   res_valid_o, NextPCSrc, mispredict_o - registered resolve result
//   br_count_o, mis_count_o - saturating performance counters
module branch_unit_pred
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc_f,
  output logic             pred_taken_f,
  input  logic             res_valid_i,
  input  logic [XLEN-1:0]  pc_e,
  input  logic [XLEN-1:0]  A,
  input  logic [XLEN-1:0]  B,
  input  logic [4:0]       BrOp,
  input  logic             pred_taken_e,
  input  logic             flush_i,
  output logic             res_valid_o,
  output logic             NextPCSrc,
  output logic             mispredict_o,
  output logic [CNT_W-1:0] br_count_o,
  output logic [CNT_W-1:0] mis_count_o
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] idx_f;
  logic [IDX_W-1:0] idx_e;
  logic             taken;
  logic             accept;
  logic             cond;
  logic             mispredict;
  logic             unused_pc_bits;

  // Word-aligned PCs: the two low bits never select an entry.
  assign idx_f = pc_f[IDX_W+1:2];
  assign idx_e = pc_e[IDX_W+1:2];
  assign unused_pc_bits = ^{pc_f[XLEN-1:IDX_W+2], pc_f[1:0],
                            pc_e[XLEN-1:IDX_W+2], pc_e[1:0]};

  // Reads the stored value only; a same-cycle update is not bypassed.
  assign pred_taken_f = bht[idx_f][1];

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .A     (A),
    .B     (B),
    .BrOp  (BrOp),
    .taken (taken)
  );

  assign accept     = res_valid_i && !flush_i;
  assign cond       = is_cond_branch(brop_t'(BrOp));
  assign mispredict = (taken != pred_taken_e);

  // Result outputs drop to zero on any cycle without an accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_o  <= 1'b0;
      NextPCSrc    <= 1'b0;
      mispredict_o <= 1'b0;
    end else begin
      res_valid_o  <= accept;
      NextPCSrc    <= accept && taken;
      mispredict_o <= accept && mispredict;
    end
  end

  // Only accepted conditional branches train the table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_RESET;
    end else if (accept && cond) begin
      bht[idx_e] <= sat_update(bht[idx_e], taken);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count_o  <= '0;
      mis_count_o <= '0;
    end else if (accept) begin
      if (cond && (br_count_o != '1))
        br_count_o <= br_count_o + CNT_ONE;
      if (mispredict && (mis_count_o != '1))
        mis_count_o <= mis_count_o + CNT_ONE;
    end
  end

endmodule
